// File: rtl/sro_run_ctrl.sv
// sro_run_ctrl: per-seed campaign sequencer driving the SRO datapath (reset, inhibitor load, start, run, report).
// Define SRO_EARLY_EXIT_EN to also leave RUN as soon as the datapath reports steady state.
module sro_run_ctrl #(
    parameter int RULES        = 32,
    parameter int LOG_RULES    = 5,
    parameter int NUM_SEEDS    = 1024,
    parameter int ROUND_NUMBER = 100
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic [LOG_RULES-1:0] inh_cfg,
    input  logic                 seed_valid,
    input  logic [63:0]          seed_data,
    output logic                 seed_ready,
    output logic                 dp_rst,
    output logic                 dp_ld_inhibitor,
    output logic [LOG_RULES-1:0] dp_sel_inhibitor,
    output logic                 dp_start,
    output logic [63:0]          dp_seed,
    input  logic [9:0]           dp_round_number,
    input  logic                 dp_steady_state,
    input  logic [RULES-1:0]     dp_network_state,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [RULES-1:0]     res_state,
    output logic                 res_steady,
    output logic [11:0]          res_idx,
    output logic                 busy,
    output logic                 done
);
    typedef enum logic [3:0] {IDLE, FETCH, DRST, DREL, LOAD, GAP, START, RUN, REPORT} state_t;
    state_t      r_state, w_next;
    logic        r_cnt;
    logic [11:0] r_idx;
    logic        w_exit, w_last, w_hs;

    always_comb begin
        w_exit = dp_round_number >= 10'(ROUND_NUMBER);
`ifdef SRO_EARLY_EXIT_EN
        w_exit = w_exit | dp_steady_state;
`endif
        w_last = r_idx == 12'(NUM_SEEDS - 1);
        w_hs   = r_state == REPORT && res_ready;
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = go ? FETCH : IDLE;
            FETCH:   w_next = seed_valid ? DRST : FETCH;
            DRST:    w_next = r_cnt ? DREL : DRST;
            DREL:    w_next = LOAD;
            LOAD:    w_next = GAP;
            GAP:     w_next = START;
            START:   w_next = RUN;
            RUN:     w_next = w_exit ? REPORT : RUN;
            REPORT:  w_next = !res_ready ? REPORT : w_last ? IDLE : FETCH;
            default: w_next = IDLE;
        endcase
    end

    assign seed_ready      = r_state == FETCH;
    assign dp_rst          = !(r_state inside {IDLE, FETCH, DRST});
    assign dp_ld_inhibitor = r_state == LOAD;
    assign dp_start        = r_state == START;
    assign res_valid       = r_state == REPORT;
    assign busy            = r_state != IDLE;
    assign done            = w_hs && w_last;

    // r_cnt marks the second DRST cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state          <= IDLE;
            r_cnt            <= 1'b0;
            r_idx            <= '0;
            dp_seed          <= '0;
            dp_sel_inhibitor <= '1;
            res_state        <= '0;
            res_steady       <= 1'b0;
            res_idx          <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= r_state == DRST && !r_cnt;
            if (r_state == IDLE && go) begin
                dp_sel_inhibitor <= inh_cfg;
                r_idx            <= '0;
            end
            if (r_state == FETCH && seed_valid)
                dp_seed <= seed_data;
            if (r_state == RUN && w_exit) begin
                res_state  <= dp_network_state;
                res_steady <= dp_steady_state;
                res_idx    <= r_idx;
            end
            if (w_hs && !w_last)
                r_idx <= r_idx + 12'd1;
        end
    end
endmodule
